updown_counter_5to31: RTL and testbench

Synchronous 5-bit up/down counter restricted to the range 5..31, with wrap-around at both ends. Supports a parallel load and a direction select. Used as a general-purpose bounded modulus counter in the datapath; the output q is a registered count.

---
 rtl/updown_counter_5to31_pkg.sv | 14 +
 rtl/updown_counter_5to31_if.sv | 24 ++
 rtl/updown_counter_5to31_next.sv | 54 +++++
 rtl/updown_counter_5to31.sv | 64 ++++++
 tb/tb_updown_counter_5to31.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/updown_counter_5to31_pkg.sv
// Shared definitions for the bounded 5..31 up/down counter.
// Optional terminal-count output is enabled by defining UPDOWN_CNT_TC_EN.
package updown_counter_5to31_pkg;

   localparam int WIDTH_DEF   = 5;
   localparam int CNT_MIN_DEF = 5;
   localparam int CNT_MAX_DEF = 31;

   typedef enum logic {
      CNT_UP   = 1'b0,
      CNT_DOWN = 1'b1
   } cnt_dir_t;

endpackage

// File: rtl/updown_counter_5to31_if.sv
// Load/direction/count bundle between the counter and its user.
// The tc signal exists only when UPDOWN_CNT_TC_EN is defined.
interface updown_counter_5to31_if
   import updown_counter_5to31_pkg::*;
   #(parameter int WIDTH = WIDTH_DEF)
   ();

   logic [WIDTH-1:0] I;
   logic             load;
   logic             mode;
   logic [WIDTH-1:0] q;
`ifdef UPDOWN_CNT_TC_EN
   logic             tc;
`endif

`ifdef UPDOWN_CNT_TC_EN
   modport master (output I, output load, output mode, input  q, input  tc);
   modport slave  (input  I, input  load, input  mode, output q, output tc);
`else
   modport master (output I, output load, output mode, input  q);
   modport slave  (input  I, input  load, input  mode, output q);
`endif

endinterface

// File: rtl/updown_counter_5to31_next.sv
// Combinational next-count logic: load clamping and wrap-around at both ends.
// The wrap flag is never raised on a load cycle.
module updown_counter_5to31_next
   import updown_counter_5to31_pkg::*;
   #(
      parameter int WIDTH   = WIDTH_DEF,
      parameter int CNT_MIN = CNT_MIN_DEF,
      parameter int CNT_MAX = CNT_MAX_DEF
   )
   (
      input  logic [WIDTH-1:0] q,
      input  logic [WIDTH-1:0] I,
      input  logic             load,
      input  cnt_dir_t         mode,
      output logic [WIDTH-1:0] next_q,
      output logic             wrap
   );

   localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(CNT_MIN);
   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(CNT_MAX);

   // Widened copy so the clamp comparisons stay meaningful for any parameter set.
   logic [31:0] load_wide;
   assign load_wide = 32'(I);

   always_comb begin
      next_q = q;
      wrap   = 1'b0;
      if (load) begin
         if (load_wide < 32'(CNT_MIN)) begin
            next_q = MIN_VAL;
         end else if (load_wide > 32'(CNT_MAX)) begin
            next_q = MAX_VAL;
         end else begin
            next_q = I;
         end
      end else if (mode == CNT_UP) begin
         if (q == MAX_VAL) begin
            next_q = MIN_VAL;
            wrap   = 1'b1;
         end else begin
            next_q = q + 1'b1;
         end
      end else begin
         if (q == MIN_VAL) begin
            next_q = MAX_VAL;
            wrap   = 1'b1;
         end else begin
            next_q = q - 1'b1;
         end
      end
   end

endmodule

// File: rtl/updown_counter_5to31.sv
// Bounded up/down counter (5..31) with parallel load; q is registered.
// Define UPDOWN_CNT_TC_EN to add the registered wrap pulse tc.
module updown_counter_5to31
   import updown_counter_5to31_pkg::*;
   #(
      parameter int WIDTH   = WIDTH_DEF,
      parameter int CNT_MIN = CNT_MIN_DEF,
      parameter int CNT_MAX = CNT_MAX_DEF
   )
   (
      input logic                   clk,
      input logic                   rst,
      updown_counter_5to31_if.slave bus
   );

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] next_q;
   logic             wrap;

   updown_counter_5to31_next #(
      .WIDTH   (WIDTH),
      .CNT_MIN (CNT_MIN),
      .CNT_MAX (CNT_MAX)
   ) u_next (
      .q      (count),
      .I      (bus.I),
      .load   (bus.load),
      .mode   (cnt_dir_t'(bus.mode)),
      .next_q (next_q),
      .wrap   (wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= WIDTH'(CNT_MIN);
      end else begin
         count <= next_q;
      end
   end

   assign bus.q = count;

`ifdef UPDOWN_CNT_TC_EN
   // wrap is already suppressed on load cycles, so tc only needs registering.
   logic tc_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tc_r <= 1'b0;
      end else begin
         tc_r <= wrap;
      end
   end

   assign bus.tc = tc_r;
`else
   logic unused_wrap;
   assign unused_wrap = wrap;
`endif

   count_in_range: assert property (@(posedge clk) disable iff (rst)
      (32'(count) >= 32'(CNT_MIN)) && (32'(count) <= 32'(CNT_MAX)));

endmodule

// File: tb/tb_updown_counter_5to31.sv
// Self-checking bench for updown_counter_5to31 against a modulo-arithmetic model.
// Checks tc as well when UPDOWN_CNT_TC_EN is defined.
module tb_updown_counter_5to31;

   logic clk;
   logic rst;

   int errors;
   int checks;
   int exp_q;
   bit exp_tc;

   updown_counter_5to31_if #(.WIDTH(5)) bus ();

   updown_counter_5to31 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the 27 legal values form a ring, so counting is modular arithmetic.
   task automatic tick();
      int old_q;
      @(posedge clk);
      old_q = exp_q;
      if (rst) begin
         exp_q  = 5;
         exp_tc = 1'b0;
      end else if (bus.load) begin
         exp_q  = (int'(bus.I) < 5) ? 5 : int'(bus.I);
         exp_tc = 1'b0;
      end else if (bus.mode == 1'b0) begin
         exp_q  = ((old_q - 5 + 1) % 27) + 5;
         exp_tc = (exp_q < old_q);
      end else begin
         exp_q  = ((old_q - 5 + 26) % 27) + 5;
         exp_tc = (exp_q > old_q);
      end
      #1;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      bus.load = 1'b0;
      bus.mode = 1'b0;
      bus.I    = '0;
      exp_q    = 5;
      exp_tc   = 1'b0;
      #1;
      checks++;
      if (bus.q !== 5'd5) begin
         errors++;
         $display("[TB] FAIL reset_initial q=%0d expected=5", bus.q);
      end
      tick();
      tick();
      checks++;
      if (bus.q !== 5'd5) begin
         errors++;
         $display("[TB] FAIL reset_hold q=%0d expected=5", bus.q);
      end
      rst = 1'b0;
      bus.load = 1'b1;
      bus.I    = 5'd12;
      tick();
      bus.load = 1'b0;
      checks++;
      if (bus.q !== 5'd12) begin
         errors++;
         $display("[TB] FAIL reset_preload q=%0d expected=12", bus.q);
      end
      #2;
      rst = 1'b1;
      #1;
      exp_q = 5;
      exp_tc = 1'b0;
      checks++;
      if (bus.q !== 5'd5) begin
         errors++;
         $display("[TB] FAIL reset_async q=%0d expected=5", bus.q);
      end
`ifdef UPDOWN_CNT_TC_EN
      checks++;
      if (bus.tc !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_tc tc=%0b expected=0", bus.tc);
      end
`endif
      tick();
      rst = 1'b0;
   endtask

   task automatic test_count_up();
      bus.load = 1'b1;
      bus.I    = 5'd8;
      bus.mode = 1'b1;
      tick();
      bus.load = 1'b0;
      bus.mode = 1'b0;
      checks++;
      if (bus.q !== 5'd8) begin
         errors++;
         $display("[TB] FAIL up_load q=%0d expected=8", bus.q);
      end
      for (int i = 0; i < 25; i++) begin
         tick();
         checks++;
         if (int'(bus.q) !== exp_q) begin
            errors++;
            $display("[TB] FAIL up_step%0d q=%0d expected=%0d", i, bus.q, exp_q);
         end
`ifdef UPDOWN_CNT_TC_EN
         checks++;
         if (bus.tc !== exp_tc) begin
            errors++;
            $display("[TB] FAIL up_tc%0d tc=%0b expected=%0b", i, bus.tc, exp_tc);
         end
`endif
      end
      checks++;
      if (bus.q !== 5'd6) begin
         errors++;
         $display("[TB] FAIL up_wrap_end q=%0d expected=6", bus.q);
      end
   endtask

   task automatic test_direction_switch();
      bus.load = 1'b1;
      bus.I    = 5'd15;
      tick();
      bus.load = 1'b0;
      bus.mode = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.q !== 5'd17) begin
         errors++;
         $display("[TB] FAIL dir_reach17 q=%0d expected=17", bus.q);
      end
      bus.mode = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         checks++;
         if (int'(bus.q) !== exp_q) begin
            errors++;
            $display("[TB] FAIL dir_step%0d q=%0d expected=%0d", i, bus.q, exp_q);
         end
`ifdef UPDOWN_CNT_TC_EN
         checks++;
         if (bus.tc !== exp_tc) begin
            errors++;
            $display("[TB] FAIL dir_tc%0d tc=%0b expected=%0b", i, bus.tc, exp_tc);
         end
`endif
      end
      checks++;
      if (bus.q !== 5'd30) begin
         errors++;
         $display("[TB] FAIL dir_wrap_end q=%0d expected=30", bus.q);
      end
   endtask

   task automatic test_clamp_load();
      bus.load = 1'b1;
      bus.I    = 5'd2;
      tick();
      checks++;
      if (bus.q !== 5'd5) begin
         errors++;
         $display("[TB] FAIL clamp_low q=%0d expected=5", bus.q);
      end
      bus.I    = 5'd31;
      bus.mode = 1'b0;
      tick();
      bus.load = 1'b0;
      checks++;
      if (bus.q !== 5'd31) begin
         errors++;
         $display("[TB] FAIL clamp_load31 q=%0d expected=31", bus.q);
      end
      tick();
      checks++;
      if (bus.q !== 5'd5) begin
         errors++;
         $display("[TB] FAIL clamp_wrap q=%0d expected=5", bus.q);
      end
`ifdef UPDOWN_CNT_TC_EN
      checks++;
      if (bus.tc !== 1'b1) begin
         errors++;
         $display("[TB] FAIL clamp_tc tc=%0b expected=1", bus.tc);
      end
`endif
   endtask

   task automatic test_priority();
      bus.load = 1'b1;
      bus.I    = 5'd10;
      tick();
      bus.I    = 5'd20;
      bus.mode = 1'b1;
      tick();
      checks++;
      if (bus.q !== 5'd20) begin
         errors++;
         $display("[TB] FAIL prio_load_over_count q=%0d expected=20", bus.q);
      end
      bus.I = 5'd25;
      rst   = 1'b1;
      #1;
      exp_q = 5;
      checks++;
      if (bus.q !== 5'd5) begin
         errors++;
         $display("[TB] FAIL prio_rst_async q=%0d expected=5", bus.q);
      end
      tick();
      checks++;
      if (bus.q !== 5'd5) begin
         errors++;
         $display("[TB] FAIL prio_rst_over_load q=%0d expected=5", bus.q);
      end
      bus.load = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 200; i++) begin
         bus.load = ($urandom_range(0, 3) == 0);
         bus.I    = 5'($urandom_range(0, 31));
         bus.mode = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (int'(bus.q) !== exp_q || bus.q < 5'd5) begin
            errors++;
            $display("[TB] FAIL rand_q%0d q=%0d expected=%0d", i, bus.q, exp_q);
         end
`ifdef UPDOWN_CNT_TC_EN
         checks++;
         if (bus.tc !== exp_tc) begin
            errors++;
            $display("[TB] FAIL rand_tc%0d tc=%0b expected=%0b", i, bus.tc, exp_tc);
         end
`endif
      end
      bus.load = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_count_up();
      test_direction_switch();
      test_clamp_load();
      test_priority();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
